step_sequencer: RTL



---
 rtl/step_sequencer_if.sv | 59 +++++
 rtl/step_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/step_sequencer_if.sv
// ---------------------------------------------------------------------------
// step_sequencer_if
//
// Purpose:
//   Groups the command handshake, the counter feedback/strobes and the
//   status outputs of step_sequencer into a single bundle.
//
// Signals:
//   cmd_valid   command present              (master -> slave)
//   cmd_ready   command can be accepted      (slave  -> master)
//   cmd_target  target count                 (master -> slave)
//   abort       cancel command in progress   (master -> slave)
//   count       live counter value           (master -> slave)
//   increment   one-cycle up strobe          (slave  -> master)
//   decrement   one-cycle down strobe        (slave  -> master)
//   busy        command in progress          (slave  -> master)
//   done        one-cycle completion pulse   (slave  -> master)
//
// Modports:
//   master  command source / counter side
//   slave   step_sequencer side
// ---------------------------------------------------------------------------
interface step_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             increment;
    logic             decrement;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid,
        output cmd_target,
        output abort,
        output count,
        input  cmd_ready,
        input  increment,
        input  decrement,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  abort,
        input  count,
        output cmd_ready,
        output increment,
        output decrement,
        output busy,
        output done
    );
endinterface

// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//
// Purpose:
//   Accepts a target value over a valid/ready handshake and drives the
//   up/down counter's increment/decrement strobes one step at a time until
//   the fed-back count equals the target. STEP_GAP idle cycles are forced
//   between consecutive steps. A registered one-cycle done pulse marks
//   completion; abort cancels without done.
//
// Parameters:
//   WIDTH     width of target and count
//   STEP_GAP  idle cycles between consecutive steps (0..15)
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high
//   bus    step_sequencer_if.slave (cmd_valid/cmd_ready/cmd_target, abort,
//          count, increment/decrement, busy, done)
//
// Build option:
//   STEP_SEQ_WRAP_EN  undefined: linear stepping, never crosses the
//                     all-ones/zero boundary.
//                     defined:   shortest path modulo 2^WIDTH, a tie at
//                     half range increments.
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter int WIDTH    = 4,
    parameter int STEP_GAP = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    step_sequencer_if.slave        bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(STEP_GAP);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [3:0]       gap_q, gap_d;
    logic             done_q, done_d;

    logic             at_target;
    logic             step_up;

    assign at_target = (bus.count == target_q);

`ifdef STEP_SEQ_WRAP_EN
    // Forward distance modulo 2^WIDTH; up when it is at most half range.
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic [WIDTH-1:0] fwd;
    assign fwd     = target_q - bus.count;
    assign step_up = (fwd <= HALF);
`else
    assign step_up = (bus.count < target_q);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        gap_d         = gap_q;
        done_d        = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.increment = 1'b0;
        bus.decrement = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    target_d = bus.cmd_target;
                    gap_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                // Priority: abort, then arrival, then step/gap countdown.
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (at_target) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (gap_q == 4'd0) begin
                    bus.increment = step_up;
                    bus.decrement = ~step_up;
                    gap_d         = GAP_LOAD;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.done = done_q;

endmodule
